bcd_score_counter: RTL

- Multi-digit packed-BCD score accumulator with a running high-score register.
- Sits directly upstream of the per-digit 7-segment decoders. Each 4-bit digit of disp_bcd drives one decoder instance's 4-bit input, least-significant digit first.
- Add/subtract requests arrive as single-cycle pulses from game logic.
- Arithmetic is digit-serial: one BCD digit per clock.

---
 rtl/bcd_score_counter_if.sv | 39 +++
 rtl/bcd_score_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_score_counter_if
// Description : Request/status bundle between game logic and the BCD score
//               counter.
//               Master side (game logic) drives:
//                 clear, add, add_amt, sub, sub_amt, show_high
//               Slave side (score counter) drives:
//                 ready, score, high, disp_bcd, new_record, sat
//               All multi-digit buses are packed BCD, digit 0 in [3:0].
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_score_counter_if #(
    parameter int DIGITS = 4
);
    logic                  clear;
    logic                  add;
    logic [3:0]            add_amt;
    logic                  sub;
    logic [3:0]            sub_amt;
    logic                  show_high;
    logic                  ready;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   high;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  new_record;
    logic                  sat;

    modport master (
        output clear, add, add_amt, sub, sub_amt, show_high,
        input  ready, score, high, disp_bcd, new_record, sat
    );

    modport slave (
        input  clear, add, add_amt, sub, sub_amt, show_high,
        output ready, score, high, disp_bcd, new_record, sat
    );
endinterface
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_score_counter
// Description : Packed-BCD score accumulator with running high score.
//               Add/subtract requests are processed digit-serially (one BCD
//               digit per clock) and committed in a final DONE cycle, with
//               saturation at all-9s / zero.
// Ports       : clk        - system clock, rising edge
//               resetn     - asynchronous active-low reset
//               bus.slave  - clear/add/sub requests, operand amounts,
//                            display select; ready, score, high, disp_bcd,
//                            new_record and sat status
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_score_counter #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    bcd_score_counter_if.slave   bus
);

    localparam int                  c_IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [1:0]          c_IDLE      = 2'd0;
    localparam logic [1:0]          c_CALC      = 2'd1;
    localparam logic [1:0]          c_DONE      = 2'd2;
    localparam logic                c_OP_ADD    = 1'b0;
    localparam logic                c_OP_SUB    = 1'b1;
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] c_ALL_NINES = {DIGITS{4'h9}};

    logic [1:0]           r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_op;
    logic [3:0]           r_opd;
    logic                 r_carry;      // carry for ADD, borrow for SUB
    logic [4*DIGITS-1:0]  r_work;
    logic [4*DIGITS-1:0]  r_score;
    logic [4*DIGITS-1:0]  r_high;
    logic                 r_new_record;
    logic                 r_sat;

    logic [3:0]           w_add_clamp;
    logic [3:0]           w_sub_clamp;
    logic [3:0]           w_cur_dig;
    logic [3:0]           w_opd_dig;
    logic [4:0]           w_tmp;
    logic [3:0]           w_res_dig;
    logic                 w_carry_nxt;
    logic [4*DIGITS-1:0]  w_work_nxt;
    logic [4*DIGITS-1:0]  w_commit;
    logic                 w_sat;

    assign w_add_clamp = (bus.add_amt > 4'd9) ? 4'd9 : bus.add_amt;
    assign w_sub_clamp = (bus.sub_amt > 4'd9) ? 4'd9 : bus.sub_amt;

    // The single-digit operand only applies to digit 0; higher digits just
    // ripple the carry/borrow.
    assign w_opd_dig = (r_idx == '0) ? r_opd : 4'd0;

    always_comb begin
        w_cur_dig = 4'd0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == c_IDX_W'(d)) begin
                w_cur_dig = r_work[4*d +: 4];
            end
        end
    end

    // One BCD digit of add/subtract.
    always_comb begin
        w_tmp       = 5'd0;
        w_res_dig   = 4'd0;
        w_carry_nxt = 1'b0;
        if (r_op == c_OP_ADD) begin
            w_tmp = {1'b0, w_cur_dig} + {1'b0, w_opd_dig} + {4'd0, r_carry};
            if (w_tmp > 5'd9) begin
                w_tmp       = w_tmp - 5'd10;
                w_carry_nxt = 1'b1;
            end
            w_res_dig = w_tmp[3:0];
        end else begin
            // w_tmp holds the amount to take away from this digit
            w_tmp = {1'b0, w_opd_dig} + {4'd0, r_carry};
            if ({1'b0, w_cur_dig} < w_tmp) begin
                w_tmp       = {1'b0, w_cur_dig} + 5'd10 - w_tmp;
                w_carry_nxt = 1'b1;
            end else begin
                w_tmp = {1'b0, w_cur_dig} - w_tmp;
            end
            w_res_dig = w_tmp[3:0];
        end
    end

    always_comb begin
        w_work_nxt = r_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_idx == c_IDX_W'(d)) begin
                w_work_nxt[4*d +: 4] = w_res_dig;
            end
        end
    end

    // A carry/borrow out of the top digit means the result left the range.
    always_comb begin
        w_commit = r_work;
        w_sat    = 1'b0;
        if (r_carry) begin
            w_sat    = 1'b1;
            w_commit = (r_op == c_OP_ADD) ? c_ALL_NINES : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_op         <= c_OP_ADD;
            r_opd        <= 4'd0;
            r_carry      <= 1'b0;
            r_work       <= '0;
            r_score      <= '0;
            r_high       <= '0;
            r_new_record <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_new_record <= 1'b0;
            r_sat        <= 1'b0;
            if (bus.clear) begin
                r_state <= c_IDLE;
                r_idx   <= '0;
                r_carry <= 1'b0;
                r_work  <= '0;
                r_score <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (bus.add || bus.sub) begin
                            r_op    <= bus.add ? c_OP_ADD : c_OP_SUB;
                            r_opd   <= bus.add ? w_add_clamp : w_sub_clamp;
                            r_work  <= r_score;
                            r_idx   <= '0;
                            r_carry <= 1'b0;
                            r_state <= c_CALC;
                        end
                    end
                    c_CALC: begin
                        r_work  <= w_work_nxt;
                        r_carry <= w_carry_nxt;
                        if (r_idx == c_LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= c_DONE;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                    c_DONE: begin
                        r_score <= w_commit;
                        r_sat   <= w_sat;
                        // Packed BCD orders the same as unsigned binary.
                        if (w_commit > r_high) begin
                            r_high       <= w_commit;
                            r_new_record <= 1'b1;
                        end
                        r_state <= c_IDLE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.ready      = (r_state == c_IDLE);
    assign bus.score      = r_score;
    assign bus.high       = r_high;
    assign bus.disp_bcd   = bus.show_high ? r_high : r_score;
    assign bus.new_record = r_new_record;
    assign bus.sat        = r_sat;

endmodule
`default_nettype wire
